arqt_mem_copier: RTL and testbench

Avalon-MM master that copies a block of 32-bit words from one region of the on-chip memory to another, one word at a time, and reports a running 32-bit checksum of the copied data. It sits between the processor-side control logic and the memory's slave port: it issues the reads and writes that the memory slave serves. It is used for buffer relocation and memory self-test without processor involvement.

---
 rtl/arqt_mem_copier.sv | 162 ++++++++++++++++
 tb/tb_arqt_mem_copier.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arqt_mem_copier.sv
// Avalon-MM master that copies a block of words from src to dst, one word at a time,
// and keeps a running modulo-2^DATA_W checksum of the copied data.
module arqt_mem_copier #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates; bus outputs are precomputed from the next state so they leave a flop
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    cnt_d      = length;
                    checksum_d = '0;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    data_d     = avm_readdata;
                    checksum_d = checksum_q + avm_readdata;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: ;
        endcase

        rd_d    = (state_d == S_RD_REQ);
        wr_d    = (state_d == S_WR_REQ);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        wdata_d = data_d;
        addr_d  = addr_q;
        if (rd_d) begin
            addr_d = src_d;
        end else if (wr_d) begin
            addr_d = dst_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign checksum       = checksum_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;

endmodule

// File: tb/tb_arqt_mem_copier.sv
// Bench for arqt_mem_copier: memory slave model with optional stalls, write scoreboard,
// table of copy commands plus hand-written overflow and mid-transfer reset sequences.
module tb_arqt_mem_copier;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 12;
    localparam int unsigned MEMSZ = 2048;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   src_addr;
    logic [AW-1:0]   dst_addr;
    logic [LW-1:0]   length;
    logic            busy;
    logic            done;
    logic [DW-1:0]   checksum;
    logic [AW-1:0]   avm_address;
    logic            avm_read;
    logic            avm_write;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [DW-1:0]   avm_readdata;
    logic            avm_readdatavalid;
    logic            avm_waitrequest;

    arqt_mem_copier #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .checksum          (checksum),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        bit            stall;
        bit            poke;
        logic [DW-1:0] ck;
        string         nm;
    } vec_t;

    wr_t           sb[$];
    vec_t          vq[$];
    logic [DW-1:0] mem [0:MEMSZ-1];
    logic [DW-1:0] mdl [0:MEMSZ-1];

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int stall_cnt = 0;
    int rv_timer = 0;
    bit stall_en = 1'b0;
    bit force_wait = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_rd;
    logic          prev_wr;
    logic [DW-1:0] prev_wdata;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Slave bookkeeping at the active edge: acceptances, stall accounting, write scoreboard
    always @(posedge clk) begin
        if (reset) begin
            rv_timer   = 0;
            prev_stall = 1'b0;
        end else begin
            chk("rw_exclusive", 32'(avm_read & avm_write), 32'd0);
            if (prev_stall) begin
                chk("hold_addr", 32'(avm_address), 32'(prev_addr));
                chk("hold_read", 32'(avm_read), 32'(prev_rd));
                chk("hold_write", 32'(avm_write), 32'(prev_wr));
                chk("hold_wdata", avm_writedata, prev_wdata);
            end
            if ((avm_read || avm_write) && avm_waitrequest) begin
                stall_cnt++;
            end
            if (avm_read && !avm_waitrequest) begin
                int lat;
                if (rv_timer != 0) begin
                    fail_now("second_outstanding_read");
                end
                lat = stall_en ? int'($urandom_range(1, 4)) : 1;
                rd_cnt++;
                rd_addr   = avm_address;
                rv_timer  = lat;
                stall_cnt = stall_cnt + lat - 1;
            end
            if (avm_write && !avm_waitrequest) begin
                wr_cnt++;
                mem[avm_address] = avm_writedata;
                if (sb.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 32'(avm_address), 32'(e.addr));
                    chk("wr_data", avm_writedata, e.data);
                end
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_addr  = avm_address;
            prev_rd    = avm_read;
            prev_wr    = avm_write;
            prev_wdata = avm_writedata;
        end
    end

    // Slave drive on the opposite edge: read data return, waitrequest, spurious valid pulses
    always @(negedge clk) begin
        if (reset) begin
            avm_readdatavalid = 1'b0;
        end else if (rv_timer != 0) begin
            rv_timer--;
            avm_readdatavalid = (rv_timer == 0);
        end else begin
            avm_readdatavalid = stall_en && ($urandom_range(0, 3) == 0);
        end
        avm_readdata = (avm_readdatavalid && rv_timer == 0 && !reset) ? mem[rd_addr] : $urandom;
        if (!force_wait) begin
            avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic reload_mem();
        for (int i = 0; i < int'(MEMSZ); i++) mem[i] = DW'(i + 1);
    endtask

    task automatic push_model(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
        for (int i = 0; i < int'(MEMSZ); i++) mdl[i] = mem[i];
        for (int k = 0; k < int'(l); k++) begin
            logic [AW-1:0] sa, da;
            sa = s + AW'(k);
            da = d + AW'(k);
            sb.push_back('{addr: da, data: mdl[sa]});
            mdl[da] = mdl[sa];
        end
    endtask

    task automatic add_vec(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                           input bit st, input bit pk, input logic [DW-1:0] ck, input string nm);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.stall = st; v.poke = pk; v.ck = ck; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_read"}, 32'(avm_read), 32'd0);
        chk({nm, "_write"}, 32'(avm_write), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_checksum"}, checksum, 32'd0);
        chk({nm, "_address"}, 32'(avm_address), 32'd0);
        chk({nm, "_wdata"}, avm_writedata, 32'd0);
        chk({nm, "_byteen"}, 32'(avm_byteenable), 32'hF);
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                            input bit st, input bit pk, input logic [DW-1:0] ck, input string nm);
        int n;
        int exp_n;
        bit seen;
        push_model(s, d, l);
        stall_en  = st;
        rd_cnt    = 0;
        wr_cnt    = 0;
        stall_cnt = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(negedge clk);
        start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); length = LW'($urandom);
        n = 1;
        chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
        chk({nm, "_read_first"}, 32'(avm_read), 32'(l != '0));
        seen = done;
        while (!seen && n < 20000) begin
            @(negedge clk);
            n++;
            start = pk && (n == 4);
            seen  = done;
        end
        start = 1'b0;
        if (!seen) begin
            fail_now({nm, "_done_wait"});
        end
        exp_n = (l == '0) ? 1 : 3 * int'(l) + 1 + stall_cnt;
        chk({nm, "_cycles"}, 32'(n), 32'(exp_n));
        chk({nm, "_checksum"}, checksum, ck);
        @(negedge clk);
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_checksum_hold"}, checksum, ck);
        chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({nm, "_reads"}, 32'(rd_cnt), 32'(l));
        chk({nm, "_writes"}, 32'(wr_cnt), 32'(l));
        stall_en = 1'b0;
        sb.delete();
    endtask

    initial begin
        int snap;
        bit hit;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        reload_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // src, dst, len, stall, poke, expected checksum with mem[i] = i+1 before each copy
        add_vec(11'd0,    11'd100,  12'd4,    1'b0, 1'b0, 32'd10,      "basic");
        add_vec(11'd2046, 11'd10,   12'd4,    1'b0, 1'b0, 32'd4098,    "wrap_src");
        add_vec(11'd20,   11'd2047, 12'd3,    1'b0, 1'b0, 32'd66,      "wrap_dst");
        add_vec(11'd0,    11'd2,    12'd4,    1'b0, 1'b0, 32'd6,       "overlap");
        add_vec(11'd5,    11'd6,    12'd1,    1'b0, 1'b0, 32'd6,       "single");
        add_vec(11'd7,    11'd8,    12'd0,    1'b0, 1'b0, 32'd0,       "zero_len");
        add_vec(11'd30,   11'd200,  12'd3,    1'b0, 1'b1, 32'd96,      "ignored_start");
        add_vec(11'd50,   11'd300,  12'd6,    1'b1, 1'b0, 32'd321,     "stall");
        add_vec(11'd2045, 11'd2046, 12'd5,    1'b1, 1'b0, 32'd10230,   "stall_wrap_overlap");
        add_vec(11'd0,    11'd0,    12'd2048, 1'b0, 1'b0, 32'd2098176, "max_len");

        foreach (vq[i]) begin
            reload_mem();
            run_copy(vq[i].src, vq[i].dst, vq[i].len, vq[i].stall, vq[i].poke, vq[i].ck, vq[i].nm);
        end

        // Checksum wraps modulo 2^32
        reload_mem();
        mem[500] = 32'hFFFF_FFFF;
        mem[501] = 32'h0000_0002;
        run_copy(11'd500, 11'd600, 12'd2, 1'b0, 1'b0, 32'h0000_0001, "ovf");

        // Reset while the second write is presented and stalled
        reload_mem();
        push_model(11'd0, 11'd400, 12'd4);
        @(negedge clk);
        start = 1'b1; src_addr = 11'd0; dst_addr = 11'd400; length = 12'd4;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (avm_write && avm_address == 11'd401) begin
                hit = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!hit) fail_now("rst_wait_word2");
        #1;
        force_wait = 1'b1;
        avm_waitrequest = 1'b1;
        reset = 1'b1;
        snap = wr_cnt;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        force_wait = 1'b0;
        sb.delete();
        repeat (10) @(negedge clk);
        chk("midrst_no_writes", 32'(wr_cnt), 32'(snap));
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        run_copy(11'd10, 11'd410, 12'd2, 1'b0, 1'b0, 32'd23, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
